// File: rtl/jtkcpu_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module   : jtkcpu_muldiv_if
//  Purpose  : Handshake/operand bundle between the KCPU ALU (master) and the
//             multi-cycle multiply/divide unit (slave).
//  Signals  : cen            clock enable
//             start          request, sampled on a cen edge while not busy
//             mode           0=divide, 1=multiply
//             sign           1=two's-complement operands
//             op0 [W-1:0]    dividend / multiplicand
//             op1 [W1-1:0]   divisor / multiplier
//             busy, done     operation in progress / one-cen-cycle result pulse
//             rslt, rslt_hi  quotient|product-low / remainder|product-high
//             v, z, n        overflow, zero, negative flags
//  Revision : 1.0  initial release
// ============================================================================
interface jtkcpu_muldiv_if #(
   parameter int W  = 16,
   parameter int W1 = 8
);
   logic          cen;
   logic          start;
   logic          mode;
   logic          sign;
   logic [W-1:0]  op0;
   logic [W1-1:0] op1;
   logic          busy;
   logic          done;
   logic [W-1:0]  rslt;
   logic [W1-1:0] rslt_hi;
   logic          v;
   logic          z;
   logic          n;

   modport master (
      output cen, start, mode, sign, op0, op1,
      input  busy, done, rslt, rslt_hi, v, z, n
   );

   modport slave (
      input  cen, start, mode, sign, op0, op1,
      output busy, done, rslt, rslt_hi, v, z, n
   );
endinterface
`default_nettype wire

// File: rtl/jtkcpu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : jtkcpu_muldiv
//  Purpose  : Radix-2 iterative signed/unsigned multiply / restoring divide
//             for wide KCPU ALU ops. Start/busy/done handshake, cen-gated.
//  Ports    : clk      clock
//             rst      asynchronous reset, active high
//             bus      jtkcpu_muldiv_if.slave (cen, start, mode, sign, op0,
//                      op1 in; busy, done, rslt, rslt_hi, v, z, n out)
//  Options  : JTKCPU_MULDIV_RADIX4_EN - two radix-2 steps per cen edge
//             (latency W/2+1 instead of W+1); W must be even.
//  Revision : 1.0  initial release
// ============================================================================
module jtkcpu_muldiv #(
   parameter int W  = 16,
   parameter int W1 = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   jtkcpu_muldiv_if.slave       bus
);

`ifdef JTKCPU_MULDIV_RADIX4_EN
   localparam int STEPS = W / 2;
   if (W % 2 != 0) begin : g_odd_w
      $error("jtkcpu_muldiv: W must be even when JTKCPU_MULDIV_RADIX4_EN is defined");
   end
`else
   localparam int STEPS = W;
`endif
   localparam int CW = $clog2(STEPS + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   // Shared accumulator: divide = {remainder, quotient/dividend},
   // multiply = {product high, product low/multiplicand}
   logic [W+W1-1:0]  r_acc;
   logic [W1-1:0]    r_b;
   logic [CW-1:0]    r_cnt;
   logic             r_mode, r_sign, r_neg_lo, r_neg_hi, r_dz;
   logic             r_busy, r_done;
   logic [W-1:0]     r_rslt;
   logic [W1-1:0]    r_rslt_hi;
   logic             r_v, r_z, r_n;

   // One radix-2 step. Divide: shift the next dividend bit into the partial
   // remainder and subtract when it fits. Multiply: add the multiplier into
   // the high half when the current multiplicand LSB is set, then shift right.
   function automatic logic [W+W1-1:0] f_step(input logic [W+W1-1:0] acc,
                                               input logic [W1-1:0]   b,
                                               input logic            mul);
      logic [W1:0]     trial;
      logic [W1:0]     sum;
      logic [W1-1:0]   diff;
      logic [W+W1-1:0] res;
      trial = {acc[W+W1-1:W], acc[W-1]};
      // Only used when trial >= b, so the true difference fits W1 bits
      diff  = trial[W1-1:0] - b;
      sum   = {1'b0, acc[W+W1-1:W]} + (acc[0] ? {1'b0, b} : {(W1+1){1'b0}});
      if (mul)
         res = {sum, acc[W-1:1]};
      else if (trial >= {1'b0, b})
         res = {diff, acc[W-2:0], 1'b1};
      else
         res = {trial[W1-1:0], acc[W-2:0], 1'b0};
      return res;
   endfunction

   // Operand capture
   logic          w_accept, w_op0_neg, w_op1_neg, w_dz;
   logic [W-1:0]  w_mag0;
   logic [W1-1:0] w_mag1;

   assign w_accept  = bus.start && !r_busy;
   assign w_op0_neg = bus.sign && bus.op0[W-1];
   assign w_op1_neg = bus.sign && bus.op1[W1-1];
   assign w_mag0    = w_op0_neg ? (~bus.op0 + 1'b1) : bus.op0;
   assign w_mag1    = w_op1_neg ? (~bus.op1 + 1'b1) : bus.op1;
   assign w_dz      = !bus.mode && (bus.op1 == '0);

   // Iteration datapath
   logic [W+W1-1:0] w_step1, w_step;
   assign w_step1 = f_step(r_acc, r_b, r_mode);
`ifdef JTKCPU_MULDIV_RADIX4_EN
   assign w_step  = f_step(w_step1, r_b, r_mode);
`else
   assign w_step  = w_step1;
`endif

   // Sign fix-up and flags
   logic [W-1:0]    w_rslt;
   logic [W1-1:0]   w_rslt_hi;
   logic [W+W1-1:0] w_prod;
   logic            w_v, w_z, w_n;

   always_comb begin
      w_prod    = r_neg_lo ? (~r_acc + 1'b1) : r_acc;
      w_rslt    = '0;
      w_rslt_hi = '0;
      w_v       = 1'b0;
      w_z       = 1'b0;
      w_n       = 1'b0;
      if (r_mode) begin
         w_rslt    = w_prod[W-1:0];
         w_rslt_hi = w_prod[W+W1-1:W];
         w_z       = (r_acc == '0);
         w_n       = w_rslt_hi[W1-1];
      end else begin
         if (r_dz) begin
            // Low byte of the raw dividend was parked in r_acc at start
            w_rslt    = '1;
            w_rslt_hi = r_acc[W1-1:0];
            w_v       = 1'b1;
         end else begin
            w_rslt    = r_neg_lo ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
            w_rslt_hi = r_neg_hi ? (~r_acc[W+W1-1:W] + 1'b1) : r_acc[W+W1-1:W];
            // A positive signed quotient of magnitude 2^(W-1) cannot be
            // represented; its bit pattern equals op0, as required
            w_v       = r_sign && !r_neg_lo && r_acc[W-1];
         end
         w_z = (w_rslt == '0);
         w_n = w_rslt[W-1];
      end
   end

   // FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= ST_IDLE;
      else if (bus.cen)
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = w_dz ? ST_FIX : ST_RUN;
         ST_RUN:  if (r_cnt == CW'(STEPS - 1)) w_state_nxt = ST_FIX;
         ST_FIX:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc     <= '0;
         r_b       <= '0;
         r_cnt     <= '0;
         r_mode    <= 1'b0;
         r_sign    <= 1'b0;
         r_neg_lo  <= 1'b0;
         r_neg_hi  <= 1'b0;
         r_dz      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_rslt    <= '0;
         r_rslt_hi <= '0;
         r_v       <= 1'b0;
         r_z       <= 1'b0;
         r_n       <= 1'b0;
      end else if (bus.cen) begin
         r_done <= (r_state == ST_FIX);
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_acc    <= {{W1{1'b0}}, (w_dz ? bus.op0 : w_mag0)};
                  r_b      <= w_mag1;
                  r_cnt    <= '0;
                  r_mode   <= bus.mode;
                  r_sign   <= bus.sign;
                  r_neg_lo <= w_op0_neg ^ w_op1_neg;
                  r_neg_hi <= w_op0_neg;
                  r_dz     <= w_dz;
                  r_busy   <= 1'b1;
               end
            end
            ST_RUN: begin
               r_acc <= w_step;
               r_cnt <= r_cnt + 1'b1;
            end
            ST_FIX: begin
               r_rslt    <= w_rslt;
               r_rslt_hi <= w_rslt_hi;
               r_v       <= w_v;
               r_z       <= w_z;
               r_n       <= w_n;
               r_busy    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.rslt    = r_rslt;
   assign bus.rslt_hi = r_rslt_hi;
   assign bus.v       = r_v;
   assign bus.z       = r_z;
   assign bus.n       = r_n;

endmodule
`default_nettype wire

// File: tb/tb_jtkcpu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtkcpu_muldiv
//  Purpose  : Directed self-checking bench for jtkcpu_muldiv (W=16, W1=8).
//             Honours JTKCPU_MULDIV_RADIX4_EN for the expected latency.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtkcpu_muldiv;
`ifdef JTKCPU_MULDIV_RADIX4_EN
   localparam int LAT = 9;
`else
   localparam int LAT = 17;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests   = 0;
   int   n_fail    = 0;
   int   cen_ratio = 1;
   int   cen_cnt   = 0;

   jtkcpu_muldiv_if #(.W(16), .W1(8)) bus();
   jtkcpu_muldiv #(.W(16), .W1(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Clock-enable pattern: one enabled edge every cen_ratio clocks
   initial begin
      bus.cen = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cen_cnt = cen_cnt + 1;
         bus.cen = ((cen_cnt % cen_ratio) == 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, observed running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a request and hold start until the unit accepts it
   task automatic launch(input logic m, input logic s, input logic [15:0] a, input logic [7:0] b);
      int k;
      k = 0;
      bus.mode = m; bus.sign = s; bus.op0 = a; bus.op1 = b; bus.start = 1'b1;
      do begin
         @(posedge clk); #2; k++;
      end while (!bus.busy && k < 20);
      bus.start = 1'b0;
      // Operands may change freely once accepted
      bus.op0 = ~a; bus.op1 = ~b; bus.mode = ~m; bus.sign = ~s;
      check("accept", {31'd0, bus.busy}, 32'd1);
   endtask

   // Count clock edges from the accept edge until done; optional stray start
   task automatic wait_done(input int poke, output int lat, output int busy_cnt);
      lat = 0;
      busy_cnt = 0;
      while (!bus.done && lat < 400) begin
         if (poke > 0 && lat == poke) begin
            bus.start = 1'b1; bus.mode = 1'b1; bus.sign = 1'b0;
            bus.op0 = 16'h1111; bus.op1 = 8'h22;
         end
         @(posedge clk); #2; lat++;
         bus.start = 1'b0;
         if (bus.busy) busy_cnt++;
      end
   endtask

   task automatic run_chk(input string tag, input logic m, input logic s,
                          input logic [15:0] a, input logic [7:0] b, input int poke,
                          input int exp_lat, input logic [15:0] r, input logic [7:0] h,
                          input logic ev, input logic ez, input logic en);
      int lat, bcnt;
      launch(m, s, a, b);
      wait_done(poke, lat, bcnt);
      check({tag, ".lat"},     lat,           exp_lat);
      check({tag, ".rslt"},    bus.rslt,      r);
      check({tag, ".rslt_hi"}, bus.rslt_hi,   h);
      check({tag, ".vzn"},     {bus.v, bus.z, bus.n}, {ev, ez, en});
      if (cen_ratio == 1) begin
         check({tag, ".busy_cycles"}, bcnt, exp_lat - 1);
         check({tag, ".busy_at_done"}, bus.busy, 1'b0);
      end
   endtask

   initial begin
      int done_seen;
      bus.start = 1'b0; bus.mode = 1'b0; bus.sign = 1'b0;
      bus.op0 = 16'h0; bus.op1 = 8'h0;

      // Reset state
      repeat (2) @(posedge clk);
      #2;
      check("reset.busy_done", {bus.busy, bus.done}, 2'b00);
      check("reset.rslt",      bus.rslt,    16'h0000);
      check("reset.rslt_hi",   bus.rslt_hi, 8'h00);
      check("reset.vzn",       {bus.v, bus.z, bus.n}, 3'b000);
      rst = 1'b0;
      @(posedge clk); #2;

      // 1: unsigned divide, then done must drop with results held
      run_chk("udiv_1000_7", 1'b0, 1'b0, 16'h03E8, 8'h07, 0, LAT, 16'h008E, 8'h06, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #2;
      check("done_clears", bus.done, 1'b0);
      check("rslt_holds",  bus.rslt, 16'h008E);

      // 2: signed divides, truncation toward zero
      run_chk("sdiv_m1000_7", 1'b0, 1'b1, 16'hFC18, 8'h07, 0, LAT, 16'hFF72, 8'hFA, 1'b0, 1'b0, 1'b1);
      run_chk("sdiv_1000_m7", 1'b0, 1'b1, 16'h03E8, 8'hF9, 0, LAT, 16'hFF72, 8'h06, 1'b0, 1'b0, 1'b1);
      // Zero quotient (started in the done cycle of the previous op)
      run_chk("udiv_5_7",     1'b0, 1'b0, 16'h0005, 8'h07, 0, LAT, 16'h0000, 8'h05, 1'b0, 1'b1, 1'b0);

      // 3: divide by zero
      run_chk("div_by_zero",  1'b0, 1'b0, 16'h1234, 8'h00, 0, 1,   16'hFFFF, 8'h34, 1'b1, 1'b0, 1'b1);

      // 4: signed overflow vs unsigned
      run_chk("sdiv_ovf",     1'b0, 1'b1, 16'h8000, 8'hFF, 0, LAT, 16'h8000, 8'h00, 1'b1, 1'b0, 1'b1);
      run_chk("udiv_8000_ff", 1'b0, 1'b0, 16'h8000, 8'hFF, 0, LAT, 16'h0080, 8'h80, 1'b0, 1'b0, 1'b0);

      // 5: multiplies
      run_chk("umul_ffff_ff", 1'b1, 1'b0, 16'hFFFF, 8'hFF, 0, LAT, 16'hFF01, 8'hFE, 1'b0, 1'b0, 1'b1);
      run_chk("smul_m2_3",    1'b1, 1'b1, 16'hFFFE, 8'h03, 0, LAT, 16'hFFFA, 8'hFF, 1'b0, 1'b0, 1'b1);
      run_chk("mul_zero",     1'b1, 1'b0, 16'h0000, 8'h55, 0, LAT, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);
      run_chk("smul_min_min", 1'b1, 1'b1, 16'h8000, 8'h80, 0, LAT, 16'h0000, 8'h40, 1'b0, 1'b0, 1'b0);

      // 6: stray start mid-operation is ignored
      run_chk("poke_ignored", 1'b0, 1'b0, 16'h03E8, 8'h07, 4, LAT, 16'h008E, 8'h06, 1'b0, 1'b0, 1'b0);

      // cen active one edge in four stretches latency fourfold
      cen_ratio = 4;
      run_chk("cen_1of4",     1'b0, 1'b0, 16'h03E8, 8'h07, 0, 4 * LAT, 16'h008E, 8'h06, 1'b0, 1'b0, 1'b0);
      cen_ratio = 1;
      repeat (6) @(posedge clk);
      #2;

      // Reset mid-RUN: immediate abort, no done pulse afterwards
      launch(1'b0, 1'b0, 16'h03E8, 8'h07);
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid.busy", bus.busy, 1'b0);
      check("rst_mid.rslt", bus.rslt, 16'h0000);
      @(posedge clk); #2;
      rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #2;
         if (bus.done || bus.busy) done_seen++;
      end
      check("rst_mid.no_done", done_seen, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
